// File: rtl/bsg_bp_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsg_bp_mem_pkg: channel-select mode encoding and address interleave macro |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`define BSG_BP_MEM_SEL(addr, lsb, sw, xor_en) \
  ((xor_en) ? (addr[(lsb) +: (sw)] ^ addr[(lsb)+(sw) +: (sw)]) : addr[(lsb) +: (sw)])

package bsg_bp_mem_pkg;

  typedef enum logic {
    e_sel_plain = 1'b0,
    e_sel_xor   = 1'b1
  } bsg_bp_mem_sel_mode_e;

endpackage
`default_nettype wire

// File: rtl/bsg_bp_mem_interleave_splitter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsg_bp_mem_interleave_splitter_if: upstream and per-channel bus bundle    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface bsg_bp_mem_interleave_splitter_if #(
  parameter int num_channels_p    = 2,
  parameter int msg_width_p       = 128,
  parameter int addr_width_p      = 40,
  parameter int max_outstanding_p = 8
);
  logic [msg_width_p-1:0]                cmd_i;
  logic [addr_width_p-1:0]               cmd_addr_i;
  logic                                  cmd_v_i;
  logic                                  cmd_ready_o;
  logic [msg_width_p-1:0]                resp_o;
  logic                                  resp_v_o;
  logic                                  resp_yumi_i;
  logic [num_channels_p*msg_width_p-1:0] chan_cmd_o;
  logic [num_channels_p-1:0]             chan_cmd_v_o;
  logic [num_channels_p-1:0]             chan_cmd_ready_i;
  logic [num_channels_p*msg_width_p-1:0] chan_resp_i;
  logic [num_channels_p-1:0]             chan_resp_v_i;
  logic [num_channels_p-1:0]             chan_resp_yumi_o;
  logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o;

  modport slave (
    input  cmd_i, cmd_addr_i, cmd_v_i, resp_yumi_i,
           chan_cmd_ready_i, chan_resp_i, chan_resp_v_i,
    output cmd_ready_o, resp_o, resp_v_o, chan_cmd_o, chan_cmd_v_o,
           chan_resp_yumi_o, outstanding_o
  );

  modport master (
    output cmd_i, cmd_addr_i, cmd_v_i, resp_yumi_i,
           chan_cmd_ready_i, chan_resp_i, chan_resp_v_i,
    input  cmd_ready_o, resp_o, resp_v_o, chan_cmd_o, chan_cmd_v_o,
           chan_resp_yumi_o, outstanding_o
  );
endinterface
`default_nettype wire

// File: rtl/bsg_bp_mem_order_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsg_bp_mem_order_tracker: ring-buffer FIFO of channel IDs with occupancy |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bsg_bp_mem_order_tracker #(
  parameter int depth_p = 8,
  parameter int width_p = 1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             enq_i,
  input  logic [width_p-1:0]               data_i,
  input  logic                             deq_i,
  output logic                             full_o,
  output logic                             empty_o,
  output logic [width_p-1:0]               head_o,
  output logic [$clog2(depth_p+1)-1:0]     count_o
);
  localparam int c_ptr_w = $clog2(depth_p);
  localparam int c_cnt_w = $clog2(depth_p + 1);

  logic [width_p-1:0] r_mem [depth_p];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_enq;
  logic               w_deq;

  assign full_o  = (r_count == c_cnt_w'(depth_p));
  assign empty_o = (r_count == '0);
  assign w_enq   = enq_i & ~full_o;
  assign w_deq   = deq_i & ~empty_o;
  assign head_o  = r_mem[r_rptr];
  assign count_o = r_count;

  // Pointers wrap naturally because depth_p is a power of two.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_deq) r_rptr <= r_rptr + c_ptr_w'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end
endmodule
`default_nettype wire

// File: rtl/bsg_bp_mem_interleave_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsg_bp_mem_interleave_splitter: N-way address-interleaved command split, |
// | in-order response merge. Revision: 1.0                                   |
// +--------------------------------------------------------------------------+
module bsg_bp_mem_interleave_splitter
  import bsg_bp_mem_pkg::*;
#(
  parameter int num_channels_p    = 2,
  parameter int msg_width_p       = 128,
  parameter int addr_width_p      = 40,
  parameter int sel_lsb_p         = 6,
  parameter int hash_mode_p       = 0,
  parameter int max_outstanding_p = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  bsg_bp_mem_interleave_splitter_if.slave  bus
);
  localparam int c_sel_w = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
  localparam int c_cnt_w = $clog2(max_outstanding_p + 1);

  logic [c_sel_w-1:0]        w_sel;
  logic [c_sel_w-1:0]        w_head;
  logic [num_channels_p-1:0] w_sel_oh;
  logic [num_channels_p-1:0] w_head_oh;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_live;
  logic                      w_enq;
  logic                      w_deq;
  logic                      w_unused_addr;

  if (num_channels_p == 1) begin : g_sel_single
    assign w_sel = '0;
  end else begin : g_sel_multi
    assign w_sel = `BSG_BP_MEM_SEL(bus.cmd_addr_i, sel_lsb_p, c_sel_w,
                                   hash_mode_p == int'(e_sel_xor));
  end
  assign w_unused_addr = ^bus.cmd_addr_i;

  always_comb begin
    w_sel_oh   = '0;
    w_head_oh  = '0;
    bus.resp_o = '0;
    for (int c = 0; c < num_channels_p; c++) begin
      w_sel_oh[c]  = (w_sel == c_sel_w'(c));
      w_head_oh[c] = (w_head == c_sel_w'(c));
      if (w_head_oh[c]) bus.resp_o = bus.chan_resp_i[c*msg_width_p +: msg_width_p];
    end
  end

  // A full tracker blocks issue even if a dequeue frees a slot this cycle.
  assign w_live               = reset_n_i & ~w_full;
  assign bus.chan_cmd_o       = {num_channels_p{bus.cmd_i}};
  assign bus.chan_cmd_v_o     = w_sel_oh & {num_channels_p{bus.cmd_v_i & w_live}};
  assign bus.cmd_ready_o      = (|(w_sel_oh & bus.chan_cmd_ready_i)) & w_live;
  assign w_enq                = bus.cmd_v_i & bus.cmd_ready_o;

  assign bus.resp_v_o         = reset_n_i & ~w_empty & (|(w_head_oh & bus.chan_resp_v_i));
  assign w_deq                = reset_n_i & ~w_empty & bus.resp_yumi_i;
  assign bus.chan_resp_yumi_o = w_head_oh & {num_channels_p{w_deq}};

  bsg_bp_mem_order_tracker #(
    .depth_p (max_outstanding_p),
    .width_p (c_sel_w)
  ) u_tracker (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq_i     (w_enq),
    .data_i    (w_sel),
    .deq_i     (w_deq),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .head_o    (w_head),
    .count_o   (bus.outstanding_o)
  );

`ifndef SYNTHESIS
  localparam bit c_pow2_ok =
    ((num_channels_p & (num_channels_p - 1)) == 0) &&
    ((max_outstanding_p & (max_outstanding_p - 1)) == 0);

  logic [c_cnt_w-1:0] r_chan_live [num_channels_p];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < num_channels_p; c++) r_chan_live[c] <= '0;
    end else begin
      assert (c_pow2_ok) else $error("channel count and tracker depth must be powers of two");
      assert (!bus.resp_yumi_i || bus.resp_v_o) else $error("resp_yumi_i without resp_v_o");
      for (int c = 0; c < num_channels_p; c++) begin
        r_chan_live[c] <= r_chan_live[c]
                        + c_cnt_w'(w_enq && (w_sel == c_sel_w'(c)))
                        - c_cnt_w'(w_deq && (w_head == c_sel_w'(c)));
        assert (!bus.chan_resp_v_i[c] || (r_chan_live[c] != '0))
          else $error("response valid on channel %0d with nothing in flight", c);
      end
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_bsg_bp_mem_interleave_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bsg_bp_mem_interleave_splitter: directed checks on N=2, N=4 and N=1   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bsg_bp_mem_interleave_splitter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bsg_bp_mem_interleave_splitter_if #(.num_channels_p(2), .msg_width_p(16),
    .addr_width_p(40), .max_outstanding_p(4)) b2 ();
  bsg_bp_mem_interleave_splitter_if #(.num_channels_p(4), .msg_width_p(16),
    .addr_width_p(40), .max_outstanding_p(8)) b4 ();
  bsg_bp_mem_interleave_splitter_if #(.num_channels_p(1), .msg_width_p(16),
    .addr_width_p(40), .max_outstanding_p(4)) b1 ();

  bsg_bp_mem_interleave_splitter #(.num_channels_p(2), .msg_width_p(16), .addr_width_p(40),
    .sel_lsb_p(6), .hash_mode_p(0), .max_outstanding_p(4))
    dut2 (.clk_i(clk), .reset_n_i(reset_n), .bus(b2));
  bsg_bp_mem_interleave_splitter #(.num_channels_p(4), .msg_width_p(16), .addr_width_p(40),
    .sel_lsb_p(6), .hash_mode_p(1), .max_outstanding_p(8))
    dut4 (.clk_i(clk), .reset_n_i(reset_n), .bus(b4));
  bsg_bp_mem_interleave_splitter #(.num_channels_p(1), .msg_width_p(16), .addr_width_p(40),
    .sel_lsb_p(6), .hash_mode_p(0), .max_outstanding_p(4))
    dut1 (.clk_i(clk), .reset_n_i(reset_n), .bus(b1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b2.cmd_v_i = 1'b1; b2.cmd_addr_i = '0; b2.chan_cmd_ready_i = 2'b11;
    tick(); tick();
    n_chk++; if (b2.outstanding_o !== 3'd0) begin n_bad++;
      $display("FAIL reset_outstanding: got %0d want 0", b2.outstanding_o); end
    n_chk++; if (b2.cmd_ready_o !== 1'b0 || b2.chan_cmd_v_o !== 2'b00) begin n_bad++;
      $display("FAIL reset_cmd: got ready=%b v=%b want ready=0 v=00", b2.cmd_ready_o, b2.chan_cmd_v_o); end
    n_chk++; if (b2.resp_v_o !== 1'b0 || b2.chan_resp_yumi_o !== 2'b00) begin n_bad++;
      $display("FAIL reset_resp: got v=%b yumi=%b want 0/00", b2.resp_v_o, b2.chan_resp_yumi_o); end
    b2.cmd_v_i = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_routing();
    logic [39:0] addrs [3] = '{40'h000, 40'h040, 40'h080};
    logic [1:0]  exp_v [3] = '{2'b01, 2'b10, 2'b01};
    logic [15:0] m;
    b2.chan_cmd_ready_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      m = 16'hA000 + 16'(i);
      b2.cmd_v_i = 1'b1; b2.cmd_addr_i = addrs[i]; b2.cmd_i = m;
      #1;
      n_chk++; if (b2.chan_cmd_v_o !== exp_v[i] || b2.cmd_ready_o !== 1'b1) begin n_bad++;
        $display("FAIL route_%0d: got v=%b ready=%b want v=%b ready=1", i, b2.chan_cmd_v_o, b2.cmd_ready_o, exp_v[i]); end
      n_chk++; if (b2.chan_cmd_o !== {m, m}) begin n_bad++;
        $display("FAIL route_bcast_%0d: got %h want %h", i, b2.chan_cmd_o, {m, m}); end
      tick();
    end
    b2.cmd_v_i = 1'b0;
    #1;
    n_chk++; if (b2.outstanding_o !== 3'd3) begin n_bad++;
      $display("FAIL route_outstanding: got %0d want 3", b2.outstanding_o); end
    b2.chan_resp_i = {16'hB001, 16'h0000}; b2.chan_resp_v_i = 2'b10;
    #1;
    n_chk++; if (b2.resp_v_o !== 1'b0 || b2.chan_resp_yumi_o !== 2'b00) begin n_bad++;
      $display("FAIL order_hold: got v=%b yumi=%b want 0/00", b2.resp_v_o, b2.chan_resp_yumi_o); end
    tick();
    b2.chan_resp_i = {16'hB001, 16'hC000}; b2.chan_resp_v_i = 2'b11; b2.resp_yumi_i = 1'b1;
    #1;
    n_chk++; if (b2.resp_v_o !== 1'b1 || b2.resp_o !== 16'hC000 || b2.chan_resp_yumi_o !== 2'b01) begin n_bad++;
      $display("FAIL order_first: got v=%b d=%h yumi=%b want 1/c000/01", b2.resp_v_o, b2.resp_o, b2.chan_resp_yumi_o); end
    tick();
    b2.chan_resp_i = {16'hB001, 16'h0000}; b2.chan_resp_v_i = 2'b10;
    #1;
    n_chk++; if (b2.resp_v_o !== 1'b1 || b2.resp_o !== 16'hB001 || b2.chan_resp_yumi_o !== 2'b10) begin n_bad++;
      $display("FAIL order_second: got v=%b d=%h yumi=%b want 1/b001/10", b2.resp_v_o, b2.resp_o, b2.chan_resp_yumi_o); end
    tick();
    b2.chan_resp_i = {16'h0000, 16'hC002}; b2.chan_resp_v_i = 2'b01;
    #1;
    n_chk++; if (b2.resp_v_o !== 1'b1 || b2.resp_o !== 16'hC002 || b2.chan_resp_yumi_o !== 2'b01) begin n_bad++;
      $display("FAIL order_third: got v=%b d=%h yumi=%b want 1/c002/01", b2.resp_v_o, b2.resp_o, b2.chan_resp_yumi_o); end
    tick();
    b2.chan_resp_v_i = 2'b00; b2.resp_yumi_i = 1'b0;
    #1;
    n_chk++; if (b2.outstanding_o !== 3'd0 || b2.resp_v_o !== 1'b0) begin n_bad++;
      $display("FAIL order_drain: got cnt=%0d v=%b want 0/0", b2.outstanding_o, b2.resp_v_o); end
  endtask

  task automatic test_full();
    b2.chan_cmd_ready_i = 2'b11;
    b2.cmd_v_i = 1'b1; b2.cmd_addr_i = 40'h0; b2.cmd_i = 16'hF000;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if (b2.cmd_ready_o !== 1'b1) begin n_bad++;
        $display("FAIL full_fill_%0d: got ready=%b want 1", i, b2.cmd_ready_o); end
      tick();
    end
    #1;
    n_chk++; if (b2.outstanding_o !== 3'd4 || b2.cmd_ready_o !== 1'b0 || b2.chan_cmd_v_o !== 2'b00) begin n_bad++;
      $display("FAIL full_stall: got cnt=%0d ready=%b v=%b want 4/0/00", b2.outstanding_o, b2.cmd_ready_o, b2.chan_cmd_v_o); end
    b2.chan_resp_i = {16'h0000, 16'hD000}; b2.chan_resp_v_i = 2'b01; b2.resp_yumi_i = 1'b1;
    #1;
    n_chk++; if (b2.cmd_ready_o !== 1'b0 || b2.chan_cmd_v_o !== 2'b00 || b2.resp_v_o !== 1'b1) begin n_bad++;
      $display("FAIL full_same_cycle: got ready=%b v=%b rv=%b want 0/00/1", b2.cmd_ready_o, b2.chan_cmd_v_o, b2.resp_v_o); end
    tick();
    b2.resp_yumi_i = 1'b0; b2.chan_resp_v_i = 2'b00;
    #1;
    n_chk++; if (b2.outstanding_o !== 3'd3 || b2.cmd_ready_o !== 1'b1) begin n_bad++;
      $display("FAIL full_freed: got cnt=%0d ready=%b want 3/1", b2.outstanding_o, b2.cmd_ready_o); end
    tick();
    b2.cmd_v_i = 1'b0;
    #1;
    n_chk++; if (b2.outstanding_o !== 3'd4) begin n_bad++;
      $display("FAIL full_refill: got %0d want 4", b2.outstanding_o); end
    b2.chan_resp_v_i = 2'b01; b2.resp_yumi_i = 1'b1;
    repeat (4) tick();
    b2.chan_resp_v_i = 2'b00; b2.resp_yumi_i = 1'b0;
    #1;
    n_chk++; if (b2.outstanding_o !== 3'd0) begin n_bad++;
      $display("FAIL full_drain: got %0d want 0", b2.outstanding_o); end
  endtask

  task automatic test_backpressure();
    b2.chan_cmd_ready_i = 2'b01;
    b2.cmd_v_i = 1'b1; b2.cmd_addr_i = 40'h040; b2.cmd_i = 16'hE000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (b2.cmd_ready_o !== 1'b0 || b2.chan_cmd_v_o !== 2'b10 || b2.outstanding_o !== 3'd0) begin n_bad++;
        $display("FAIL bp_wait_%0d: got ready=%b v=%b cnt=%0d want 0/10/0", i, b2.cmd_ready_o, b2.chan_cmd_v_o, b2.outstanding_o); end
      tick();
    end
    b2.chan_cmd_ready_i = 2'b11;
    #1;
    n_chk++; if (b2.cmd_ready_o !== 1'b1) begin n_bad++;
      $display("FAIL bp_release: got ready=%b want 1", b2.cmd_ready_o); end
    tick();
    b2.cmd_v_i = 1'b0;
    tick();
    n_chk++; if (b2.outstanding_o !== 3'd1) begin n_bad++;
      $display("FAIL bp_single_xfer: got %0d want 1", b2.outstanding_o); end
    b2.cmd_v_i = 1'b1; b2.cmd_addr_i = 40'h000;
    tick(); tick();
    b2.cmd_v_i = 1'b0;
  endtask

  task automatic test_reset_midflight();
    #1;
    n_chk++; if (b2.outstanding_o !== 3'd3) begin n_bad++;
      $display("FAIL midreset_pre: got %0d want 3", b2.outstanding_o); end
    reset_n = 1'b0; b2.chan_resp_v_i = 2'b11; b2.chan_resp_i = {16'h1111, 16'h2222};
    tick();
    n_chk++; if (b2.outstanding_o !== 3'd0 || b2.resp_v_o !== 1'b0 || b2.chan_resp_yumi_o !== 2'b00) begin n_bad++;
      $display("FAIL midreset: got cnt=%0d v=%b yumi=%b want 0/0/00", b2.outstanding_o, b2.resp_v_o, b2.chan_resp_yumi_o); end
    b2.chan_resp_v_i = 2'b00;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_hash();
    logic [39:0] addrs [3] = '{40'h1C0, 40'h0C0, 40'h100};
    logic [3:0]  exp_v [3] = '{4'b0100, 4'b1000, 4'b0010};
    b4.chan_cmd_ready_i = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      b4.cmd_v_i = 1'b1; b4.cmd_addr_i = addrs[i]; b4.cmd_i = 16'h4000 + 16'(i);
      #1;
      n_chk++; if (b4.chan_cmd_v_o !== exp_v[i] || b4.cmd_ready_o !== 1'b1) begin n_bad++;
        $display("FAIL hash_%0d: got v=%b ready=%b want v=%b ready=1", i, b4.chan_cmd_v_o, b4.cmd_ready_o, exp_v[i]); end
      tick();
    end
    b4.cmd_v_i = 1'b0;
    b4.chan_resp_i = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    b4.chan_resp_v_i = 4'b1100; b4.resp_yumi_i = 1'b1;
    #1;
    n_chk++; if (b4.resp_o !== 16'h2222 || b4.chan_resp_yumi_o !== 4'b0100) begin n_bad++;
      $display("FAIL hash_resp0: got d=%h yumi=%b want 2222/0100", b4.resp_o, b4.chan_resp_yumi_o); end
    tick();
    b4.chan_resp_v_i = 4'b1010;
    #1;
    n_chk++; if (b4.resp_o !== 16'h3333 || b4.chan_resp_yumi_o !== 4'b1000) begin n_bad++;
      $display("FAIL hash_resp1: got d=%h yumi=%b want 3333/1000", b4.resp_o, b4.chan_resp_yumi_o); end
    tick();
    b4.chan_resp_v_i = 4'b0010;
    #1;
    n_chk++; if (b4.resp_o !== 16'h1111 || b4.chan_resp_yumi_o !== 4'b0010) begin n_bad++;
      $display("FAIL hash_resp2: got d=%h yumi=%b want 1111/0010", b4.resp_o, b4.chan_resp_yumi_o); end
    tick();
    b4.chan_resp_v_i = 4'b0000; b4.resp_yumi_i = 1'b0;
    #1;
    n_chk++; if (b4.outstanding_o !== 4'd0) begin n_bad++;
      $display("FAIL hash_drain: got %0d want 0", b4.outstanding_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cmds  [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic [39:0] addrs [3] = '{40'h0, 40'hFC0, 40'h12340};
    logic [2:0]  exp_cnt;
    b1.chan_cmd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b1.cmd_v_i = (i < 3);
      if (i < 3) begin b1.cmd_addr_i = addrs[i]; b1.cmd_i = cmds[i]; end
      b1.chan_resp_v_i = (i > 0); b1.resp_yumi_i = (i > 0);
      b1.chan_resp_i = 16'h5000 + 16'(i);
      #1;
      if (i < 3) begin
        n_chk++; if (b1.chan_cmd_v_o !== 1'b1 || b1.cmd_ready_o !== 1'b1 || b1.chan_cmd_o !== cmds[i]) begin n_bad++;
          $display("FAIL single_cmd_%0d: got v=%b ready=%b d=%h want 1/1/%h", i, b1.chan_cmd_v_o, b1.cmd_ready_o, b1.chan_cmd_o, cmds[i]); end
      end
      if (i > 0) begin
        n_chk++; if (b1.resp_v_o !== 1'b1 || b1.resp_o !== 16'h5000 + 16'(i) || b1.chan_resp_yumi_o !== 1'b1) begin n_bad++;
          $display("FAIL single_resp_%0d: got v=%b d=%h yumi=%b want 1/%h/1", i, b1.resp_v_o, b1.resp_o, b1.chan_resp_yumi_o, 16'h5000 + 16'(i)); end
      end else begin
        n_chk++; if (b1.resp_v_o !== 1'b0) begin n_bad++;
          $display("FAIL single_empty: got v=%b want 0", b1.resp_v_o); end
      end
      tick();
      exp_cnt = (i < 3) ? 3'd1 : 3'd0;
      n_chk++; if (b1.outstanding_o !== exp_cnt) begin n_bad++;
        $display("FAIL single_cnt_%0d: got %0d want %0d", i, b1.outstanding_o, exp_cnt); end
    end
    b1.cmd_v_i = 1'b0; b1.chan_resp_v_i = 1'b0; b1.resp_yumi_i = 1'b0;
  endtask

  initial begin
    b2.cmd_i = '0; b2.cmd_addr_i = '0; b2.cmd_v_i = 1'b0; b2.resp_yumi_i = 1'b0;
    b2.chan_cmd_ready_i = '0; b2.chan_resp_i = '0; b2.chan_resp_v_i = '0;
    b4.cmd_i = '0; b4.cmd_addr_i = '0; b4.cmd_v_i = 1'b0; b4.resp_yumi_i = 1'b0;
    b4.chan_cmd_ready_i = '0; b4.chan_resp_i = '0; b4.chan_resp_v_i = '0;
    b1.cmd_i = '0; b1.cmd_addr_i = '0; b1.cmd_v_i = 1'b0; b1.resp_yumi_i = 1'b0;
    b1.chan_cmd_ready_i = '0; b1.chan_resp_i = '0; b1.chan_resp_v_i = '0;
    test_reset();
    test_routing();
    test_full();
    test_backpressure();
    test_reset_midflight();
    test_hash();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
